// File: rtl/button_conditioner_if.sv
// Push-button bundle between the board pins and the service logic: raw in, conditioned out.
// Latency: none; this only carries signals.
// Backpressure: none; every output is a level or a single-cycle pulse.
interface button_conditioner_if #(
    parameter int N = 5
);
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pulse;
    logic [N-1:0] btn_release;

    // The button source drives the raw pins and consumes the conditioned result.
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  btn_release
    );

    // The conditioner samples the raw pins and drives the conditioned result.
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output btn_release
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel 2-flop sync + debounce FSM producing level, press pulse and release pulse (optional BTN_AUTOREPEAT_EN).
// Latency: a change stable from before edge 1 shows on the registered outputs after edge DEBOUNCE_CYCLES+2.
// Backpressure: none; pulses last one cycle and are not held, so consumers must sample every clk cycle.
module button_conditioner #(
    parameter int N               = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic               clk,
    input  logic               resetn,
    button_conditioner_if.slave btn
);

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        ARM      = 2'd1,
        PRESSED  = 2'd2,
        DISARM   = 2'd3
    } state_t;

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets the FSM cannot honour (a 1-sample debounce, or a
    // repeat period longer than the initial delay, which the reload scheme relies on).
    if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
        $error("button_conditioner: illegal DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
    end

    logic [N-1:0]  sync1_q;
    logic [N-1:0]  sync_q;
    state_t        state_q [N];
    state_t        state_d [N];
    logic [CW-1:0] cnt_q   [N];
    logic [CW-1:0] cnt_d   [N];
    logic [N-1:0]  level_d;
    logic [N-1:0]  pulse_d;
    logic [N-1:0]  release_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam int            RW         = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
    // Reloading to DELAY-PERIOD makes the next hit of RPT_LAST exactly PERIOD cycles later.
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RW-1:0] rpt_q [N];
    logic [RW-1:0] rpt_d [N];
`endif

    // Two-flop synchronizer; only sync_q feeds the state machines.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= btn.btn_raw;
            sync_q  <= sync1_q;
        end
    end

    // Debounce next-state, counter and edge-pulse decode for every channel.
    always_comb begin
        pulse_d   = '0;
        release_d = '0;
        level_d   = '0;
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
`ifdef BTN_AUTOREPEAT_EN
            rpt_d[i]   = rpt_q[i];
`endif
            case (state_q[i])
                RELEASED: begin
`ifdef BTN_AUTOREPEAT_EN
                    rpt_d[i] = '0;
`endif
                    if (sync_q[i]) begin
                        state_d[i] = ARM;
                        cnt_d[i]   = CW'(1);
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                ARM: begin
`ifdef BTN_AUTOREPEAT_EN
                    rpt_d[i] = '0;
`endif
                    if (!sync_q[i]) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = PRESSED;
                        pulse_d[i] = 1'b1;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!sync_q[i]) begin
                        // Repeat count freezes while the release is being qualified.
                        state_d[i] = DISARM;
                        cnt_d[i]   = CW'(1);
                    end else begin
`ifdef BTN_AUTOREPEAT_EN
                        if (rpt_q[i] == RPT_LAST) begin
                            pulse_d[i] = 1'b1;
                            rpt_d[i]   = RPT_RELOAD;
                        end else begin
                            rpt_d[i]   = rpt_q[i] + RW'(1);
                        end
`endif
                    end
                end
                DISARM: begin
                    if (sync_q[i]) begin
                        state_d[i]   = PRESSED;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]   = RELEASED;
                        cnt_d[i]     = '0;
                        release_d[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rpt_d[i]     = '0;
`endif
                    end else begin
                        cnt_d[i]     = cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                    cnt_d[i]   = '0;
                end
            endcase
            level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == DISARM);
        end
    end

    // State, counters and registered outputs; reset drops every channel to RELEASED.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
`ifdef BTN_AUTOREPEAT_EN
                rpt_q[i]   <= '0;
`endif
            end
            btn.btn_level   <= '0;
            btn.btn_pulse   <= '0;
            btn.btn_release <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef BTN_AUTOREPEAT_EN
                rpt_q[i]   <= rpt_d[i];
`endif
            end
            btn.btn_level   <= level_d;
            btn.btn_pulse   <= pulse_d;
            btn.btn_release <= release_d;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
// Expected vectors are hand-derived: press/release land after edge 6 of a stable raw run.
module tb_button_conditioner;

    localparam int N = 5;

    logic clk;
    logic resetn;
    int   pass_cnt;
    int   total_cnt;

    button_conditioner_if #(.N(N)) bif ();

    button_conditioner #(
        .N              (N),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .btn   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then land on the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn      = 1'b0;
        bif.btn_raw = 5'b11111;
        for (int k = 1; k <= 3; k++) begin
            tick();
            total_cnt++;
            if ({bif.btn_level, bif.btn_pulse, bif.btn_release} !== 15'd0) begin
                $display("FAIL reset_hold k=%0d lvl/pls/rel got %b/%b/%b want 0/0/0",
                         k, bif.btn_level, bif.btn_pulse, bif.btn_release);
            end else pass_cnt++;
        end
        bif.btn_raw = '0;
        resetn      = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            total_cnt++;
            if ({bif.btn_level, bif.btn_pulse, bif.btn_release} !== 15'd0) begin
                $display("FAIL reset_idle k=%0d lvl/pls/rel got %b/%b/%b want 0/0/0",
                         k, bif.btn_level, bif.btn_pulse, bif.btn_release);
            end else pass_cnt++;
        end
    endtask

    // Clean press on channel 0 held 20 cycles, then a clean release.
    task automatic test_clean_press();
        logic [4:0] el, ep, er;
        bif.btn_raw = 5'b00001;
        for (int k = 1; k <= 20; k++) begin
            tick();
            el = (k >= 6) ? 5'b00001 : 5'b00000;
            ep = (k == 6) ? 5'b00001 : 5'b00000;
            er = 5'b00000;
            total_cnt++;
            if ({bif.btn_level, bif.btn_pulse, bif.btn_release} !== {el, ep, er}) begin
                $display("FAIL clean_press k=%0d lvl/pls/rel got %b/%b/%b want %b/%b/%b",
                         k, bif.btn_level, bif.btn_pulse, bif.btn_release, el, ep, er);
            end else pass_cnt++;
        end
        bif.btn_raw = 5'b00000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            el = (k < 6)  ? 5'b00001 : 5'b00000;
            ep = 5'b00000;
            er = (k == 6) ? 5'b00001 : 5'b00000;
            total_cnt++;
            if ({bif.btn_level, bif.btn_pulse, bif.btn_release} !== {el, ep, er}) begin
                $display("FAIL clean_release k=%0d lvl/pls/rel got %b/%b/%b want %b/%b/%b",
                         k, bif.btn_level, bif.btn_pulse, bif.btn_release, el, ep, er);
            end else pass_cnt++;
        end
    endtask

    // Channel 2 bounces with 3-sample highs; nothing may come out.
    task automatic test_bounce_reject();
        logic [27:0] pat;
        pat = 28'b1110_0111_0000_0000_0000_0000_0000;
        for (int k = 0; k < 28; k++) begin
            bif.btn_raw = {2'b00, pat[27-k], 2'b00};
            tick();
            total_cnt++;
            if ({bif.btn_level, bif.btn_pulse, bif.btn_release} !== 15'd0) begin
                $display("FAIL bounce_reject k=%0d lvl/pls/rel got %b/%b/%b want 0/0/0",
                         k, bif.btn_level, bif.btn_pulse, bif.btn_release);
            end else pass_cnt++;
        end
    endtask

    // Channel 3 held, then a 2-cycle drop, 5 highs, and a final 10-cycle low run.
    task automatic test_release_bounce();
        logic [4:0] el, ep, er;
        bif.btn_raw = 5'b01000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            el = (k >= 6) ? 5'b01000 : 5'b00000;
            ep = (k == 6) ? 5'b01000 : 5'b00000;
            total_cnt++;
            if ({bif.btn_level, bif.btn_pulse, bif.btn_release} !== {el, ep, 5'b00000}) begin
                $display("FAIL rel_bounce_press k=%0d lvl/pls/rel got %b/%b/%b want %b/%b/00000",
                         k, bif.btn_level, bif.btn_pulse, bif.btn_release, el, ep);
            end else pass_cnt++;
        end
        for (int k = 1; k <= 7; k++) begin
            bif.btn_raw = (k <= 2) ? 5'b00000 : 5'b01000;
            tick();
            total_cnt++;
            if ({bif.btn_level, bif.btn_pulse, bif.btn_release} !== {5'b01000, 10'd0}) begin
                $display("FAIL rel_bounce_drop k=%0d lvl/pls/rel got %b/%b/%b want 01000/00000/00000",
                         k, bif.btn_level, bif.btn_pulse, bif.btn_release);
            end else pass_cnt++;
        end
        bif.btn_raw = 5'b00000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            el = (k < 6)  ? 5'b01000 : 5'b00000;
            er = (k == 6) ? 5'b01000 : 5'b00000;
            total_cnt++;
            if ({bif.btn_level, bif.btn_pulse, bif.btn_release} !== {el, 5'b00000, er}) begin
                $display("FAIL rel_bounce_final k=%0d lvl/pls/rel got %b/%b/%b want %b/00000/%b",
                         k, bif.btn_level, bif.btn_pulse, bif.btn_release, el, er);
            end else pass_cnt++;
        end
    endtask

    // Channels 0 and 4 pressed on the same edge, then released together.
    task automatic test_simultaneous();
        logic [4:0] el, ep, er;
        bif.btn_raw = 5'b10001;
        for (int k = 1; k <= 10; k++) begin
            tick();
            el = (k >= 6) ? 5'b10001 : 5'b00000;
            ep = (k == 6) ? 5'b10001 : 5'b00000;
            total_cnt++;
            if ({bif.btn_level, bif.btn_pulse, bif.btn_release} !== {el, ep, 5'b00000}) begin
                $display("FAIL simul_press k=%0d lvl/pls/rel got %b/%b/%b want %b/%b/00000",
                         k, bif.btn_level, bif.btn_pulse, bif.btn_release, el, ep);
            end else pass_cnt++;
        end
        bif.btn_raw = 5'b00000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            el = (k < 6)  ? 5'b10001 : 5'b00000;
            er = (k == 6) ? 5'b10001 : 5'b00000;
            total_cnt++;
            if ({bif.btn_level, bif.btn_pulse, bif.btn_release} !== {el, 5'b00000, er}) begin
                $display("FAIL simul_release k=%0d lvl/pls/rel got %b/%b/%b want %b/00000/%b",
                         k, bif.btn_level, bif.btn_pulse, bif.btn_release, el, er);
            end else pass_cnt++;
        end
    endtask

    // Channel 1 already held; channel 4 starts debouncing and reset hits at cycle 3.
    task automatic test_reset_mid();
        logic [4:0] el, ep, er;
        bif.btn_raw = 5'b00010;
        for (int k = 1; k <= 8; k++) tick();
        total_cnt++;
        if (bif.btn_level !== 5'b00010) begin
            $display("FAIL reset_mid_pre level got %b want 00010", bif.btn_level);
        end else pass_cnt++;
        bif.btn_raw = 5'b10010;
        tick();
        tick();
        resetn = 1'b0;
        #1;
        total_cnt++;
        if ({bif.btn_level, bif.btn_pulse, bif.btn_release} !== 15'd0) begin
            $display("FAIL reset_mid_async lvl/pls/rel got %b/%b/%b want 0/0/0",
                     bif.btn_level, bif.btn_pulse, bif.btn_release);
        end else pass_cnt++;
        for (int k = 1; k <= 2; k++) begin
            tick();
            total_cnt++;
            if ({bif.btn_level, bif.btn_pulse, bif.btn_release} !== 15'd0) begin
                $display("FAIL reset_mid_low k=%0d lvl/pls/rel got %b/%b/%b want 0/0/0",
                         k, bif.btn_level, bif.btn_pulse, bif.btn_release);
            end else pass_cnt++;
        end
        resetn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            el = (k >= 6) ? 5'b10010 : 5'b00000;
            ep = (k == 6) ? 5'b10010 : 5'b00000;
            total_cnt++;
            if ({bif.btn_level, bif.btn_pulse, bif.btn_release} !== {el, ep, 5'b00000}) begin
                $display("FAIL reset_mid_after k=%0d lvl/pls/rel got %b/%b/%b want %b/%b/00000",
                         k, bif.btn_level, bif.btn_pulse, bif.btn_release, el, ep);
            end else pass_cnt++;
        end
        bif.btn_raw = 5'b00000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            el = (k < 6)  ? 5'b10010 : 5'b00000;
            er = (k == 6) ? 5'b10010 : 5'b00000;
            total_cnt++;
            if ({bif.btn_level, bif.btn_pulse, bif.btn_release} !== {el, 5'b00000, er}) begin
                $display("FAIL reset_mid_release k=%0d lvl/pls/rel got %b/%b/%b want %b/00000/%b",
                         k, bif.btn_level, bif.btn_pulse, bif.btn_release, el, er);
            end else pass_cnt++;
        end
    endtask

    // Channel 1 held for 30 cycles: press pulse at edge 6, repeats at 16,19,...,31 when enabled.
    task automatic test_autorepeat();
        logic [4:0] el, ep, er;
        bit         rpt;
        for (int k = 1; k <= 40; k++) begin
            bif.btn_raw = (k <= 30) ? 5'b00010 : 5'b00000;
            tick();
`ifdef BTN_AUTOREPEAT_EN
            rpt = (k >= 16) && (k <= 32) && (((k - 16) % 3) == 0);
`else
            rpt = 1'b0;
`endif
            el = (k >= 6 && k <= 35) ? 5'b00010 : 5'b00000;
            ep = (k == 6 || rpt)     ? 5'b00010 : 5'b00000;
            er = (k == 36)           ? 5'b00010 : 5'b00000;
            total_cnt++;
            if ({bif.btn_level, bif.btn_pulse, bif.btn_release} !== {el, ep, er}) begin
                $display("FAIL autorepeat k=%0d lvl/pls/rel got %b/%b/%b want %b/%b/%b",
                         k, bif.btn_level, bif.btn_pulse, bif.btn_release, el, ep, er);
            end else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        resetn      = 1'b0;
        bif.btn_raw = '0;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce_reject();
        test_release_bounce();
        test_simultaneous();
        test_reset_mid();
        test_autorepeat();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the raw push-button inputs before they reach the top-level service logic (time set, alarm set, stopwatch, mini game).
- Per channel: 2-flop synchronizer, debounce state machine, and edge outputs.
- Outputs: a clean level, a one-cycle press pulse and a one-cycle release pulse.
- Sits directly upstream of the top-level push[4:0] consumers and runs on the board oscillator clock.

Parameters:
- N, 5, number of button channels (u, d, l, r, m).
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required to accept a change. Legal range ≥ 2. Default is 10 ms at 100 MHz.
- REPEAT_DELAY, 50000000, cycles held in PRESSED before the first auto-repeat pulse. Used only with BTN_AUTOREPEAT_EN.
- REPEAT_PERIOD, 20000000, cycles between subsequent auto-repeat pulses. Used only with BTN_AUTOREPEAT_EN.

Ports:
- clk  in  1  board oscillator clock (clk_osc domain).
- resetn  in  1  asynchronous active-low reset.
- btn_raw  in  N  raw asynchronous button inputs, active-high.
- btn_level  out  N  debounced level, 1 = held.
- btn_pulse  out  N  one-cycle pulse on accepted press (and on auto-repeat when enabled).
- btn_release  out  N  one-cycle pulse on accepted release.

Behaviour:
- Reset (resetn=0, asynchronous): all synchronizer flops, counters and state cleared. Every channel enters RELEASED. btn_level, btn_pulse and btn_release are all 0.
- Deassertion of resetn takes effect at the next clk edge. Reset mid-debounce discards progress with no pulse.
- Synchronizer: raw -> s1 -> s. All state-machine decisions use s only.
- Channels are fully independent. Each has its own counter of width clog2(DEBOUNCE_CYCLES+1).
- States per channel (btn_level = 1 in PRESSED and DISARM):
  - RELEASED: if s=1 -> ARM, cnt=1. Else stay, cnt=0.
  - ARM: if s=0 -> RELEASED, cnt=0, no pulse. Else if cnt=DEBOUNCE_CYCLES-1 -> PRESSED, btn_level<=1, btn_pulse=1 for exactly one cycle. Else cnt+1.
  - PRESSED: if s=0 -> DISARM, cnt=1. Else stay.
  - DISARM: if s=1 -> PRESSED, no pulses. Else if cnt=DEBOUNCE_CYCLES-1 -> RELEASED, btn_level<=0, btn_release=1 for one cycle. Else cnt+1.
- Latency: raw stable from before edge 1 -> btn_level/btn_pulse asserted after edge DEBOUNCE_CYCLES+2. Release latency is identical.
- A glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no pulse and no level change. This holds for glitches while released and while held.
- btn_pulse and btn_release are never both high on the same channel in the same cycle.
- Counters saturate at DEBOUNCE_CYCLES-1 and never wrap.
- Outputs are registered, with no combinational path from btn_raw.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: each channel has a repeat counter, cleared on entry to PRESSED and held at 0 outside PRESSED.
  - After REPEAT_DELAY cycles continuously in PRESSED, btn_pulse fires one cycle, then again every REPEAT_PERIOD cycles while in PRESSED.
  - DISARM freezes the repeat counter. A return to PRESSED from DISARM resumes counting without resetting it.
  - No repeat pulse is issued on the cycle the press pulse fires.
- Not defined: btn_pulse fires only once per accepted press. Repeat counters and the REPEAT_* parameters are unused and no logic is synthesized for them.

Test Plan:
- Use DEBOUNCE_CYCLES=4 (and REPEAT_DELAY=10, REPEAT_PERIOD=3 where noted) for all scenarios.
- Clean press: btn_raw[0] 0->1 held 20 cycles.
  - Required: btn_pulse[0] high exactly one cycle, after edge 6.
  - Required: btn_level[0]=1 from edge 6.
  - Required: other channels stay 0.
- Bounce reject: btn_raw[2] pulses 1 for 3 cycles, 0 for 2, 1 for 3, then 0 for 20.
  - Required: no btn_pulse, no btn_level change.
- Release with bounce: held channel, raw drops 0 for 2 cycles, back to 1 for 5, then 0 for 10.
  - Required: a single btn_release after edge 6 of the final low run.
  - Required: btn_level stays 1 through the 2-cycle drop.
- Simultaneous channels: btn_raw = 5'b10001 at the same edge.
  - Required: btn_pulse = 5'b10001 in the same single cycle.
- Reset mid-debounce: raw goes high, resetn pulled low at cycle 3 for 2 cycles, raw stays high.
  - Required: all outputs 0 during reset.
  - Required: after release, press pulse at DEBOUNCE_CYCLES+2 edges after resetn rises.
- BTN_AUTOREPEAT_EN defined: hold btn_raw[1] for 30 cycles.
  - Required: btn_pulse[1] at press, then at 10, 13, 16, 19 ... cycles after press until release.
  - Required without the macro: only the press pulse.
